// File: rtl/fir_ram_mac_ctrl.sv
// Sequencer ahead of the 4-way SpSram/MAC selector: loads 40 coefficients into the RAMs
// and, per input sample, issues 40 pipelined reads with MAC enables and an output strobe.
module fir_ram_mac_ctrl #(
  parameter int NUM_MOD = 4,
  parameter int NUM_TAP = 10,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCoeffUpdateFlag,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  output logic              oLoadDone,
  input  logic              iInValid,
  output logic              oInReady,
  output logic [1:0]        oModuleSel,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWtDtRam,
  output logic              oAccClr,
  output logic              oEnMul,
  output logic              oEnAddAcc,
  output logic              oOutValid
);

  localparam int TOTAL = NUM_MOD * NUM_TAP;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, LOAD, LDONE, RUN} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   tap_q, tap_d;
  logic [1:0]          mod_q, mod_d;
  logic                rd_vld_p0;
  logic [1:0]          rd_sel_p0;
  logic                coeff_rdy_q, load_done_q, in_rdy_q;
  logic [1:0]          sel_q;
  logic                csn_q, wrn_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdat_q;
  logic                acc_clr_q, en_mul_q, en_add_q, out_vld_q;
  logic                in_acc, beat_acc, run_done;

  // Tap address walks 0..NUM_TAP-1, carrying into the sub-module index.
  always_comb begin
    tap_d = tap_q + ADDR_W'(1);
    mod_d = mod_q;
    if (tap_q == ADDR_W'(NUM_TAP - 1)) begin
      tap_d = '0;
      mod_d = mod_q + 2'd1;
    end
  end

  // The update flag wins over a sample offered in the same cycle.
  assign in_acc   = (state_q == IDLE) && in_rdy_q && iInValid && !iCoeffUpdateFlag;
  assign beat_acc = coeff_rdy_q && iCoeffValid && iCoeffUpdateFlag;
  assign run_done = (state_q == RUN) && en_add_q && !en_mul_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tap_q       <= '0;
      mod_q       <= '0;
      rd_vld_p0   <= 1'b0;
      rd_sel_p0   <= '0;
      coeff_rdy_q <= 1'b0;
      load_done_q <= 1'b0;
      in_rdy_q    <= 1'b0;
      sel_q       <= '0;
      csn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      addr_q      <= '0;
      wdat_q      <= '0;
      acc_clr_q   <= 1'b0;
      en_mul_q    <= 1'b0;
      en_add_q    <= 1'b0;
      out_vld_q   <= 1'b0;
    end else begin
      csn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      addr_q      <= '0;
      wdat_q      <= '0;
      acc_clr_q   <= 1'b0;
      load_done_q <= 1'b0;
      out_vld_q   <= 1'b0;
      in_rdy_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          sel_q    <= '0;
          en_mul_q <= 1'b0;
          en_add_q <= 1'b0;
          if (iCoeffUpdateFlag) begin
            state_q     <= LOAD;
            coeff_rdy_q <= 1'b1;
            cnt_q       <= '0;
            tap_q       <= '0;
            mod_q       <= '0;
          end else if (in_acc) begin
            state_q   <= RUN;
            acc_clr_q <= 1'b1;
            csn_q     <= 1'b0;
            addr_q    <= tap_q;
            rd_sel_p0 <= mod_q;
            rd_vld_p0 <= 1'b1;
            tap_q     <= tap_d;
            mod_q     <= mod_d;
            cnt_q     <= cnt_q + CNT_W'(1);
          end else begin
            in_rdy_q <= 1'b1;
          end
        end
        LOAD: begin
          sel_q <= '0;
          if (!iCoeffUpdateFlag) begin
            state_q     <= IDLE;
            coeff_rdy_q <= 1'b0;
            cnt_q       <= '0;
            tap_q       <= '0;
            mod_q       <= '0;
          end else if (beat_acc) begin
            csn_q  <= 1'b0;
            wrn_q  <= 1'b0;
            sel_q  <= mod_q;
            addr_q <= tap_q;
            wdat_q <= iCoeffData;
            if (cnt_q == CNT_W'(TOTAL - 1)) begin
              state_q     <= LDONE;
              load_done_q <= 1'b1;
              coeff_rdy_q <= 1'b0;
              cnt_q       <= '0;
              tap_q       <= '0;
              mod_q       <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              tap_q <= tap_d;
              mod_q <= mod_d;
            end
          end
        end
        LDONE: begin
          sel_q <= '0;
          if (!iCoeffUpdateFlag) state_q <= IDLE;
        end
        RUN: begin
          // Read issue (p0) -> multiply (RAM latency 1) -> accumulate; select tracks multiply.
          en_mul_q <= rd_vld_p0;
          en_add_q <= en_mul_q;
          sel_q    <= rd_sel_p0;
          if (cnt_q != CNT_W'(TOTAL)) begin
            csn_q     <= 1'b0;
            addr_q    <= tap_q;
            rd_sel_p0 <= mod_q;
            rd_vld_p0 <= 1'b1;
            tap_q     <= tap_d;
            mod_q     <= mod_d;
            cnt_q     <= cnt_q + CNT_W'(1);
          end else begin
            rd_vld_p0 <= 1'b0;
          end
          if (run_done) begin
            state_q   <= IDLE;
            out_vld_q <= 1'b1;
            sel_q     <= '0;
            cnt_q     <= '0;
            tap_q     <= '0;
            mod_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oCoeffReady = coeff_rdy_q;
  assign oLoadDone   = load_done_q;
  assign oInReady    = in_rdy_q;
  assign oModuleSel  = sel_q;
  assign oCsnRam     = csn_q;
  assign oWrnRam     = wrn_q;
  assign oAddrRam    = addr_q;
  assign oWtDtRam    = wdat_q;
  assign oAccClr     = acc_clr_q;
  assign oEnMul      = en_mul_q;
  assign oEnAddAcc   = en_add_q;
  assign oOutValid   = out_vld_q;

endmodule

// File: tb/tb_fir_ram_mac_ctrl.sv
// Self-checking bench for fir_ram_mac_ctrl: coefficient load/abort, sample run timing,
// collisions and resets, compared against an offset-based reference model.
module tb_fir_ram_mac_ctrl;

  logic        iClk = 1'b0;
  logic        iRst, iCoeffUpdateFlag, iCoeffValid, iInValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady, oLoadDone, oInReady, oCsnRam, oWrnRam;
  logic        oAccClr, oEnMul, oEnAddAcc, oOutValid;
  logic [1:0]  oModuleSel;
  logic [3:0]  oAddrRam;
  logic [15:0] oWtDtRam;

  int n_checks = 0;
  int n_fail   = 0;

  fir_ram_mac_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iCoeffUpdateFlag(iCoeffUpdateFlag),
    .iCoeffValid(iCoeffValid), .iCoeffData(iCoeffData), .oCoeffReady(oCoeffReady),
    .oLoadDone(oLoadDone), .iInValid(iInValid), .oInReady(oInReady),
    .oModuleSel(oModuleSel), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam),
    .oWtDtRam(oWtDtRam), .oAccClr(oAccClr), .oEnMul(oEnMul), .oEnAddAcc(oEnAddAcc),
    .oOutValid(oOutValid)
  );

  always #5 iClk = ~iClk;

  logic [30:0] obs, obs_nosel;
  assign obs = {oModuleSel, oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oAccClr, oEnMul,
                oEnAddAcc, oOutValid, oCoeffReady, oLoadDone, oInReady};
  assign obs_nosel = {2'b00, obs[28:0]};

  function automatic logic [30:0] pack(input logic [1:0] sel, input logic csn, input logic wrn,
                                       input logic [3:0] addr, input logic [15:0] wd,
                                       input logic clr, input logic mul, input logic add,
                                       input logic ov, input logic crdy, input logic ldone,
                                       input logic irdy);
    return {sel, csn, wrn, addr, wd, clr, mul, add, ov, crdy, ldone, irdy};
  endfunction

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic wait_ready;
    int w = 0;
    while (oInReady !== 1'b1 && w < 100) begin
      iInValid = 1'b0;
      tick();
      w++;
    end
    n_checks++;
    if (oInReady !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready timeout got=%b exp=1", oInReady);
    end
  endtask

  task automatic test_reset;
    iRst = 1'b1; iCoeffUpdateFlag = 1'b0; iCoeffValid = 1'b0; iCoeffData = '0; iInValid = 1'b0;
    tick(); tick();
    n_checks++;
    if (obs !== pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", obs, pack(0,1,1,0,0,0,0,0,0,0,0,0));
    end
    iRst = 1'b0;
    tick();
    n_checks++;
    if (obs !== pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
      n_fail++; $display("FAIL first_idle got=%h exp=%h", obs, pack(0,1,1,0,0,0,0,0,0,0,0,1));
    end
  endtask

  // stop < 40 aborts after that many accepted beats.
  task automatic test_load(input int stop, input bit rand_data, input bit gaps);
    logic [15:0] coeff [40];
    logic [30:0] exp;
    int  k = 0;
    int  guard = 0;
    bit  prev = 1'b0;
    for (int i = 0; i < 40; i++) coeff[i] = rand_data ? 16'($urandom) : 16'(i + 1);
    iCoeffUpdateFlag = 1'b1; iCoeffValid = 1'b0; iInValid = 1'b0;
    tick();
    while (1) begin
      if (prev) exp = pack(2'((k - 1) / 10), 0, 0, 4'((k - 1) % 10), coeff[k - 1],
                           0, 0, 0, 0, (k < 40), (k == 40), 0);
      else      exp = pack(0, 1, 1, 0, 0, 0, 0, 0, 0, (k < 40), 0, 0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL load_beat k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 40 || k == stop) break;
      if (guard++ > 400) begin
        n_fail++; $display("FAIL load_timeout k=%0d exp=%0d", k, stop); break;
      end
      prev = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      iCoeffValid = prev;
      iCoeffData  = prev ? coeff[k] : 16'($urandom);
      tick();
      if (prev) k++;
    end
    exp = pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (k == 40) begin
      iCoeffValid = 1'b1; iCoeffData = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        tick();
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL load_done_hold i=%0d got=%h exp=%h", i, obs, exp);
        end
      end
      iCoeffUpdateFlag = 1'b0; iCoeffValid = 1'b0;
      tick();
    end else begin
      iCoeffUpdateFlag = 1'b0; iCoeffValid = 1'b1; iCoeffData = 16'hDEAD;
      tick();
      iCoeffValid = 1'b0;
    end
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL load_exit got=%h exp=%h", obs, exp);
    end
    tick();
    n_checks++;
    if (oInReady !== 1'b1) begin
      n_fail++; $display("FAIL load_back_idle ready got=%b exp=1", oInReady);
    end
  endtask

  // Observes offsets d=1..44 after acceptance; returns while observing d=44.
  task automatic test_run(input bit flag_mid, input bit hold_valid, input bit rand_delay);
    logic [30:0] exp;
    bit rd;
    wait_ready();
    if (rand_delay) repeat ($urandom_range(0, 3)) begin iInValid = 1'b0; tick(); end
    iInValid = 1'b1;
    tick();
    for (int d = 1; d <= 44; d++) begin
      rd  = (d >= 1 && d <= 40);
      exp = pack(0, !rd, 1, rd ? 4'((d - 1) % 10) : 4'd0, 0, (d == 1), (d >= 2 && d <= 41),
                 (d >= 3 && d <= 42), (d == 43), (flag_mid && d == 44), 0,
                 (!flag_mid && d == 44));
      n_checks++;
      if (obs_nosel !== exp) begin
        n_fail++; $display("FAIL run_cycle d=%0d got=%h exp=%h", d, obs_nosel, exp);
      end
      if (d >= 2 && d <= 41) begin
        n_checks++;
        if (oModuleSel !== 2'((d - 2) / 10)) begin
          n_fail++; $display("FAIL run_sel d=%0d got=%0d exp=%0d", d, oModuleSel, (d - 2) / 10);
        end
      end
      iInValid = hold_valid ? 1'b1 : ((d <= 40) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (flag_mid && d == 20) iCoeffUpdateFlag = 1'b1;
      if (d < 44) tick();
    end
  endtask

  task automatic test_back_to_back;
    test_run(0, 1, 0);
    test_run(0, 0, 0);
  endtask

  task automatic test_collision;
    logic [30:0] exp;
    wait_ready();
    iCoeffUpdateFlag = 1'b1; iInValid = 1'b1;
    exp = pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL collision i=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    iCoeffUpdateFlag = 1'b0; iInValid = 1'b0;
    tick(); tick();
    n_checks++;
    if (oInReady !== 1'b1) begin
      n_fail++; $display("FAIL collision_idle ready got=%b exp=1", oInReady);
    end
  endtask

  task automatic test_flag_mid_run;
    test_run(1, 0, 1);
    iCoeffUpdateFlag = 1'b0; iInValid = 1'b0;
    tick();
    n_checks++;
    if (obs !== pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL flag_mid_abort got=%h exp=%h", obs, pack(0,1,1,0,0,0,0,0,0,0,0,0));
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    wait_ready();
    iInValid = 1'b1;
    tick();
    iInValid = 1'b0;
    repeat (19) tick();
    n_checks++;
    if (oEnMul !== 1'b1 || oCsnRam !== 1'b0) begin
      n_fail++; $display("FAIL mid_run_active got=%b%b exp=10", oEnMul, oCsnRam);
    end
    iRst = 1'b1;
    tick();
    n_checks++;
    if (obs !== pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_mid_run got=%h exp=%h", obs, pack(0,1,1,0,0,0,0,0,0,0,0,0));
    end
    iRst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (obs !== pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
        n_fail++; $display("FAIL post_reset_idle i=%0d got=%h exp=%h", i, obs,
                           pack(0,1,1,0,0,0,0,0,0,0,0,1));
      end
    end
    test_run(0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_load(40, 0, 0);
    test_run(0, 0, 0);
    test_load(15, 1, 1);
    test_load(40, 1, 1);
    test_run(0, 0, 1);
    test_back_to_back();
    test_collision();
    test_flag_mid_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
